// File: rtl/pattern_pkg.sv
// Shared state encoding and input-conditioning helpers for the pattern sequencer.
package pattern_pkg;

  localparam int MAX_LEN_DEF = 16;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_EMIT = 2'd1;
  localparam state_t S_GAP  = 2'd2;
  localparam state_t S_DONE = 2'd3;

  function automatic int clamp_len(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

  // A zero gap would let two strobes touch, so the minimum is one idle cycle.
  function automatic int eff_gap(input int g);
    return (g == 0) ? 1 : g;
  endfunction

endpackage

// File: rtl/pattern_shift_reg.sv
// Left-shifting pattern store; keeps the aligned load value so later passes can reload it.
module pattern_shift_reg #(
  parameter int MAX_LEN = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [MAX_LEN-1:0] load_val,
  input  logic               shift,
  input  logic               reload,
  output logic               msb
);

  logic [MAX_LEN-1:0] sr;
  logic [MAX_LEN-1:0] copy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr   <= '0;
      copy <= '0;
    end else if (load) begin
      sr   <= load_val;
      copy <= load_val;
    end else if (reload) begin
      sr <= copy;
    end else if (shift) begin
      sr <= {sr[MAX_LEN-2:0], 1'b0};
    end
  end

  assign msb = sr[MAX_LEN-1];

endmodule

// File: rtl/pattern_sequencer.sv
// Serial pattern transmitter: emits a latched pattern MSB-first as data/trig strobes
// separated by a programmable gap, optionally repeating the whole pattern.
module pattern_sequencer
  import pattern_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int GAP_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   length,
  input  logic [GAP_W-1:0]   gap,
  input  logic [3:0]         repeat_cnt,
  output logic               data,
  output logic               trig,
  output logic               busy,
  output logic               done
);

  state_t             state;
  logic [LEN_W-1:0]   len_c;
  logic [LEN_W-1:0]   shamt;
  logic [LEN_W-1:0]   len_l;
  logic [LEN_W-1:0]   bit_cnt;
  logic [GAP_W-1:0]   gap_e;
  logic [GAP_W-1:0]   gap_l;
  logic [GAP_W-1:0]   gap_cnt;
  logic [3:0]         pass_cnt;
  logic               sent_bit;
  logic               msb;
  logic               load;
  logic               shift;
  logic               reload;

  assign len_c = LEN_W'(clamp_len(int'(length), MAX_LEN));
  assign gap_e = GAP_W'(eff_gap(int'(gap)));
  // Left-justify so that bit length-1 lands on the MSB.
  assign shamt = LEN_W'(MAX_LEN) - len_c;

  assign load   = (state == S_IDLE) && start && !abort && (length != '0);
  assign shift  = (state == S_EMIT) && !abort;
  assign reload = (state == S_GAP) && !abort && (gap_cnt == '0) &&
                  (bit_cnt == '0) && (pass_cnt != '0);

  pattern_shift_reg #(.MAX_LEN(MAX_LEN)) u_shift (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (pattern << shamt),
    .shift    (shift),
    .reload   (reload),
    .msb      (msb)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      len_l    <= '0;
      bit_cnt  <= '0;
      gap_l    <= '0;
      gap_cnt  <= '0;
      pass_cnt <= '0;
      sent_bit <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            if (length == '0) begin
              state <= S_DONE;
            end else begin
              len_l    <= len_c;
              gap_l    <= gap_e;
              pass_cnt <= repeat_cnt;
              bit_cnt  <= len_c - 1'b1;
              state    <= S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            sent_bit <= msb;
            gap_cnt  <= gap_l - 1'b1;
            state    <= S_GAP;
          end
        end
        S_GAP: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 1'b1;
            state   <= S_EMIT;
          end else if (pass_cnt != '0) begin
            pass_cnt <= pass_cnt - 1'b1;
            bit_cnt  <= len_l - 1'b1;
            state    <= S_EMIT;
          end else begin
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from registers so an asynchronous reset clears them at once.
  assign trig = (state == S_EMIT);
  assign busy = (state == S_EMIT) || (state == S_GAP);
  assign done = (state == S_DONE);
  assign data = (state == S_EMIT) ? msb : ((state == S_GAP) ? sent_bit : 1'b0);

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer: per-cycle checks against the strobe timing formulas.
module tb_pattern_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] pattern;
  logic [4:0]  length;
  logic [7:0]  gap;
  logic [3:0]  repeat_cnt;
  logic        data;
  logic        trig;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pattern_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .pattern    (pattern),
    .length     (length),
    .gap        (gap),
    .repeat_cnt (repeat_cnt),
    .data       (data),
    .trig       (trig),
    .busy       (busy),
    .done       (done)
  );

  // Minimal detector stand-in: shifts in data on each trig, one led per target.
  logic [7:0] rx;
  logic       rx_clr;
  logic [1:0] led;

  always @(posedge clk) begin
    if (rx_clr) rx <= 8'h00;
    else if (trig) rx <= {rx[6:0], data};
  end

  assign led = {rx == 8'h5A, rx == 8'hB4};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts a sequence (start sampled at edge 0) and checks cycles 1..ncyc.
  task automatic run_seq(input string name, input logic [15:0] pat, input logic [4:0] len,
                         input logic [7:0] g, input logic [3:0] rep, input int ncyc,
                         input int abort_at, input bit noise);
    int   lm, ge, per, tot, kg;
    logic et, ed, eb, edn, prev_t;
    lm  = (len > 16) ? 16 : int'(len);
    ge  = (g == 0) ? 1 : int'(g);
    per = 1 + ge;
    tot = (int'(rep) + 1) * lm * per;
    pattern    = pat;
    length     = len;
    gap        = g;
    repeat_cnt = rep;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    prev_t = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (abort_at != 0 && c > abort_at) begin
        {et, ed, eb, edn} = 4'b0;
      end else begin
        eb  = (c <= tot);
        edn = (c == tot + 1);
        et  = eb && ((c - 1) % per == 0);
        ed  = 1'b0;
        if (eb) begin
          kg = (c - 1) / per;
          ed = pat[lm - 1 - (kg % lm)];
        end
      end
      chk($sformatf("%s trig c%0d", name, c), trig, et);
      chk($sformatf("%s data c%0d", name, c), data, ed);
      chk($sformatf("%s busy c%0d", name, c), busy, eb);
      chk($sformatf("%s done c%0d", name, c), done, edn);
      chk($sformatf("%s trig_pair c%0d", name, c), prev_t & trig, 1'b0);
      prev_t = trig;
      abort  = (c == abort_at);
      if (noise) begin
        if (c < tot + 1) begin
          start   = 1'b1;
          pattern = 16'($urandom);
          length  = 5'($urandom_range(1, 16));
          gap     = 8'($urandom_range(0, 3));
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; rx_clr = 1'b1;
    pattern = '0; length = '0; gap = '0; repeat_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset trig", trig, 1'b0);
    chk("reset data", data, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    @(negedge clk);
    reset = 1'b0; rx_clr = 1'b0;

    run_seq("basic", 16'h00B4, 5'd8, 8'd3, 4'd0, 35, 0, 1'b0);
    chk("loopback led", led, 2'b01);

    run_seq("mingap", 16'h0005, 5'd3, 8'd0, 4'd0, 9, 0, 1'b0);
    run_seq("repeat", 16'h0002, 5'd2, 8'd1, 4'd2, 15, 0, 1'b0);
    run_seq("zerolen", 16'hFFFF, 5'd0, 8'd2, 4'd0, 3, 0, 1'b0);
    run_seq("clamp", 16'hA5C3, 5'd31, 8'd1, 4'd0, 35, 0, 1'b0);

    run_seq("abort", 16'h00B4, 5'd8, 8'd3, 4'd0, 7, 6, 1'b0);
    run_seq("restart", 16'h00B4, 5'd8, 8'd3, 4'd0, 35, 0, 1'b1);

    // abort together with start in IDLE must not launch a sequence
    start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; abort = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("abort_start busy c%0d", c), busy, 1'b0);
      chk($sformatf("abort_start trig c%0d", c), trig, 1'b0);
      chk($sformatf("abort_start done c%0d", c), done, 1'b0);
    end

    // asynchronous reset while in GAP
    pattern = 16'h0008; length = 5'd4; gap = 8'd5; repeat_cnt = 4'd0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("rst_pre trig", trig, 1'b1);
    @(negedge clk);
    chk("rst_pre busy", busy, 1'b1);
    chk("rst_pre data", data, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async trig", trig, 1'b0);
    chk("rst_async data", data, 1'b0);
    chk("rst_async busy", busy, 1'b0);
    chk("rst_async done", done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    run_seq("post_reset", 16'h0005, 5'd3, 8'd0, 4'd0, 9, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
